piece_queue: RTL and testbench



---
 rtl/tetris_pkg.sv | 21 ++
 rtl/bag_fallback_pick.sv | 20 ++
 rtl/piece_queue.sv | 152 +++++++++++++++
 tb/tb_piece_queue.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece encoding for the tetris datapath.
//   piece_t     3-bit tetromino ID
//   PIECE_*     IDs of the seven tetrominoes (I,O,T,S,Z,J,L = 0..6)
//   NUM_PIECES  pieces per bag
//   BAG_FULL    bag mask with every piece issued
package tetris_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t PIECE_I = 3'd0;
  localparam piece_t PIECE_O = 3'd1;
  localparam piece_t PIECE_T = 3'd2;
  localparam piece_t PIECE_S = 3'd3;
  localparam piece_t PIECE_Z = 3'd4;
  localparam piece_t PIECE_J = 3'd5;
  localparam piece_t PIECE_L = 3'd6;

  localparam int NUM_PIECES = 7;
  localparam logic [NUM_PIECES-1:0] BAG_FULL = 7'h7F;

endpackage

// File: rtl/bag_fallback_pick.sv
// bag_fallback_pick: combinational lowest-zero-bit encoder over a bag mask.
// Returns the lowest-index piece not yet issued in the current bag.
//   bag_mask  in   7  bit p set = piece p already issued
//   pick      out  3  lowest piece whose mask bit is clear (PIECE_I if none)
module bag_fallback_pick
  import tetris_pkg::*;
(
  input  logic [NUM_PIECES-1:0] bag_mask,
  output piece_t                pick
);

  // Scan from the top down so the last hit is the lowest clear bit.
  always_comb begin
    pick = PIECE_I;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!bag_mask[i]) pick = piece_t'(i);
    end
  end

endmodule

// File: rtl/piece_queue.sv
// piece_queue: turns the randomizer's 3-bit stream into an ordered queue of
// upcoming tetromino IDs. Slot 0 is the head handed to the game FSM on spawn;
// all slots are exposed for the preview renderer.
//
// Build option: PIECE_BAG_EN
//   defined   - 7-bag rule: a piece is accepted only once per bag; after
//               MAX_TRIES consecutive rejections the lowest unused piece is
//               forced in, so a push always happens within MAX_TRIES cycles.
//   undefined - every sample is accepted (7 maps to piece 0), bag_mask is 0.
//
// Ports:
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   rnd_in       in   3        random sample, considered every cycle
//   take         in   1        single-cycle pop request
//   piece_out    out  3        head of queue
//   piece_valid  out  1        queue non-empty
//   preview      out  3*DEPTH  slot k at bits [3k+2:3k]
//   count        out  4        number of valid slots
//   bag_mask     out  7        pieces already issued in the current bag
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            rnd_in,
  input  logic                  take,
  output logic [2:0]            piece_out,
  output logic                  piece_valid,
  output logic [3*DEPTH-1:0]    preview,
  output logic [3:0]            count,
  output logic [NUM_PIECES-1:0] bag_mask
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  piece_t     slot_reg  [DEPTH];
  piece_t     slot_next [DEPTH];
  logic [3:0] count_reg, count_next;
  logic       valid_reg;

  logic       pop, can_push, push;
  logic [3:0] wr_idx;
  piece_t     push_val, fallback_piece;
  logic [NUM_PIECES-1:0] bag_view;

  assign pop = take && (count_reg != 4'd0);
  // When full, a slot only frees up if the head is popped on the same edge.
  assign can_push = (count_reg < DEPTH_C) || take;

  bag_fallback_pick u_pick (
    .bag_mask (bag_view),
    .pick     (fallback_piece)
  );

`ifdef PIECE_BAG_EN
  localparam logic [3:0] RETRY_LAST = 4'(MAX_TRIES - 1);

  logic [NUM_PIECES-1:0] bag_reg, bag_next, push_bit;
  logic [3:0]            retry_reg, retry_next;
  logic [7:0]            used_ext;
  logic                  accept, fallback;

  assign bag_view = bag_reg;
  // Bit 7 is forced set so a sample of 7 reads as "already used".
  assign used_ext = {1'b1, bag_reg};
  assign accept   = !used_ext[rnd_in];
  assign fallback = !accept && (retry_reg == RETRY_LAST);
  assign push     = can_push && (accept || fallback);
  assign push_val = accept ? piece_t'(rnd_in) : fallback_piece;
  assign push_bit = 7'(8'd1 << push_val);

  always_comb begin
    bag_next = bag_reg;
    if (push) begin
      bag_next = bag_reg | push_bit;
      // Completing the bag starts a fresh one on the same edge.
      if (bag_next == BAG_FULL) bag_next = '0;
    end
  end

  always_comb begin
    retry_next = retry_reg;
    if (can_push) retry_next = push ? 4'd0 : retry_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bag_reg   <= '0;
      retry_reg <= 4'd0;
    end else begin
      bag_reg   <= bag_next;
      retry_reg <= retry_next;
    end
  end

  assign bag_mask = bag_reg;
`else
  // Retry limit only matters when the bag rule is built.
  logic unused_max_tries;
  assign unused_max_tries = (MAX_TRIES != 0);

  // With an empty bag view the picker yields piece 0, which is where 7 maps.
  assign bag_view = '0;
  assign push     = can_push;
  assign push_val = (rnd_in == 3'd7) ? fallback_piece : piece_t'(rnd_in);
  assign bag_mask = '0;
`endif

  always_comb begin
    wr_idx     = count_reg - {3'd0, pop};
    count_next = count_reg + {3'd0, push} - {3'd0, pop};
    for (int k = 0; k < DEPTH; k++) slot_next[k] = slot_reg[k];
    if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++) slot_next[k] = slot_reg[k+1];
      slot_next[DEPTH-1] = PIECE_I;
    end
    // New piece lands behind whatever survives the pop.
    if (push) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_idx == 4'(k)) slot_next[k] = push_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 4'd0;
      valid_reg <= 1'b0;
      for (int k = 0; k < DEPTH; k++) slot_reg[k] <= PIECE_I;
    end else begin
      count_reg <= count_next;
      valid_reg <= (count_next != 4'd0);
      for (int k = 0; k < DEPTH; k++) slot_reg[k] <= slot_next[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_preview
      assign preview[3*gi +: 3] = slot_reg[gi];
    end
  endgenerate

  assign piece_out   = slot_reg[0];
  assign piece_valid = valid_reg;
  assign count       = count_reg;

endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue: directed vectors for piece_queue (DEPTH=4, MAX_TRIES=8).
// The driver applies one input set per cycle and queues the hand-computed
// state expected after that edge; a monitor pops and checks after each edge.
module tb_piece_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rnd_in = 3'd0;
  logic        take = 1'b0;
  logic [2:0]  piece_out;
  logic        piece_valid;
  logic [11:0] preview;
  logic [3:0]  count;
  logic [6:0]  bag_mask;

  piece_queue #(.DEPTH(4), .MAX_TRIES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rnd_in      (rnd_in),
    .take        (take),
    .piece_out   (piece_out),
    .piece_valid (piece_valid),
    .preview     (preview),
    .count       (count),
    .bag_mask    (bag_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cnt;
    logic [11:0] prev;
    logic [6:0]  bag;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [11:0] pv(input logic [2:0] s0, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [2:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic step(input logic r, input logic [2:0] rnd, input logic tk,
                      input logic [3:0] cnt, input logic [11:0] prev,
                      input logic [6:0] bag, input string nm);
    exp_t e;
    @(negedge clk);
    reset  = r;
    rnd_in = rnd;
    take   = tk;
    e.cnt  = cnt;
    e.prev = prev;
    e.bag  = bag;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: check the state settled after each active edge.
  initial begin
    exp_t e;
    logic exp_valid;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_valid = (e.cnt != 4'd0);
        n_vec++;
        if (count !== e.cnt || piece_valid !== exp_valid || piece_out !== e.prev[2:0] ||
            preview !== e.prev || bag_mask !== e.bag) begin
          n_miss++;
          $display("FAIL %s: got count=%0d valid=%0b head=%0d preview=%h bag=%b, want count=%0d valid=%0b head=%0d preview=%h bag=%b",
                   e.name, count, piece_valid, piece_out, preview, bag_mask,
                   e.cnt, exp_valid, e.prev[2:0], e.prev, e.bag);
        end else begin
          $display("ok   %s: count=%0d head=%0d preview=%h bag=%b",
                   e.name, count, piece_out, preview, bag_mask);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, pv(0,0,0,0), 7'h00, "reset_state");
`ifdef PIECE_BAG_EN
    // Duplicate rejected, then a new piece accepted.
    step(0, 3, 0, 1, pv(3,0,0,0), 7'h08, "push_3");
    step(0, 3, 0, 1, pv(3,0,0,0), 7'h08, "dup_3_rejected");
    step(0, 5, 0, 2, pv(3,5,0,0), 7'h28, "push_5");
    step(1, 0, 0, 0, pv(0,0,0,0), 7'h00, "reset_1");
    // Whole bag streamed through with take held; bag clears on piece 6.
    step(0, 0, 0, 1, pv(0,0,0,0), 7'h01, "bag_0");
    step(0, 1, 1, 1, pv(1,0,0,0), 7'h03, "bag_1");
    step(0, 2, 1, 1, pv(2,0,0,0), 7'h07, "bag_2");
    step(0, 3, 1, 1, pv(3,0,0,0), 7'h0F, "bag_3");
    step(0, 4, 1, 1, pv(4,0,0,0), 7'h1F, "bag_4");
    step(0, 5, 1, 1, pv(5,0,0,0), 7'h3F, "bag_5");
    step(0, 6, 1, 1, pv(6,0,0,0), 7'h00, "bag_6_complete");
    step(0, 0, 0, 2, pv(6,0,0,0), 7'h01, "new_bag_0");
    // Build bag {0..4} with three queued, then starve on a used piece.
    step(1, 0, 0, 0, pv(0,0,0,0), 7'h00, "reset_2");
    step(0, 0, 0, 1, pv(0,0,0,0), 7'h01, "fill_0");
    step(0, 1, 0, 2, pv(0,1,0,0), 7'h03, "fill_1");
    step(0, 2, 0, 3, pv(0,1,2,0), 7'h07, "fill_2");
    step(0, 3, 1, 3, pv(1,2,3,0), 7'h0F, "fill_3_pop");
    step(0, 4, 1, 3, pv(2,3,4,0), 7'h1F, "fill_4_pop");
    for (int i = 0; i < 7; i++)
      step(0, 2, 0, 3, pv(2,3,4,0), 7'h1F, $sformatf("reject_%0d", i + 1));
    step(0, 2, 0, 4, pv(2,3,4,5), 7'h3F, "fallback_5");
    // Full queue: take+push shifts, take=0 holds.
    step(0, 6, 1, 4, pv(3,4,5,6), 7'h00, "full_take_push_6");
    step(0, 0, 0, 4, pv(3,4,5,6), 7'h00, "full_hold");
    // Empty take with a rejected sample does nothing.
    step(1, 0, 0, 0, pv(0,0,0,0), 7'h00, "reset_3");
    step(0, 7, 1, 0, pv(0,0,0,0), 7'h00, "empty_take_rnd7");
    step(0, 1, 0, 1, pv(1,0,0,0), 7'h02, "partial_1");
    step(0, 2, 0, 2, pv(1,2,0,0), 7'h06, "partial_2");
    step(1, 5, 1, 0, pv(0,0,0,0), 7'h00, "reset_midfill");
`else
    // Every sample accepted; 7 becomes piece 0, duplicates allowed.
    step(0, 4, 0, 1, pv(4,0,0,0), 7'h00, "push_4");
    step(0, 4, 0, 2, pv(4,4,0,0), 7'h00, "push_4_again");
    step(0, 7, 0, 3, pv(4,4,0,0), 7'h00, "push_7_as_0");
    step(0, 2, 0, 4, pv(4,4,0,2), 7'h00, "push_2_full");
    step(0, 5, 0, 4, pv(4,4,0,2), 7'h00, "full_hold");
    step(0, 6, 1, 4, pv(4,0,2,6), 7'h00, "full_take_push_6");
    step(0, 1, 1, 4, pv(0,2,6,1), 7'h00, "full_take_push_1");
    step(1, 3, 0, 0, pv(0,0,0,0), 7'h00, "reset_full");
    // Take on an empty queue is ignored; the push still happens.
    step(0, 7, 1, 1, pv(0,0,0,0), 7'h00, "empty_take_rnd7");
    step(0, 3, 1, 1, pv(3,0,0,0), 7'h00, "take_push_single");
    step(0, 5, 0, 2, pv(3,5,0,0), 7'h00, "push_5");
    step(0, 6, 1, 2, pv(5,6,0,0), 7'h00, "take_push_6");
    step(0, 1, 0, 3, pv(5,6,1,0), 7'h00, "push_1");
    step(1, 2, 1, 0, pv(0,0,0,0), 7'h00, "reset_midfill");
`endif
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop in case the clock loop ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
